// File: rtl/heavyhash_xor_pack.sv
// Takes the PE-array row sums, keeps a nibble from each row and packs them into a product vector.
// The product is XORed with the SHA3 hash and handed to the final SHA3 stage.
module heavyhash_xor_pack #(
  parameter int NPE    = 16,
  parameter int NROWS  = 64,
  parameter int PE_W   = 14,
  parameter int SHIFT  = 10,
  parameter int HASH_W = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  hash_valid,
  input  logic [HASH_W-1:0]     hash_in,
  output logic                  hash_ready,
  input  logic                  pe_valid,
  input  logic [NPE*PE_W-1:0]   pe_data,
  output logic                  pe_ready,
  output logic                  out_valid,
  output logic [HASH_W-1:0]     out_data,
  input  logic                  out_ready
);

  localparam int NBEAT = NROWS / NPE;
  localparam int CW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_OUT     = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [HASH_W-1:0] prod_q, prod_d;
  logic [HASH_W-1:0] hash_q, hash_d;
  logic [HASH_W-1:0] out_q, out_d;
  logic [HASH_W-1:0] beat_w;
  logic [PE_W-1:0]   sh_w;
  logic              last_w;
  int                row_w;

  assign last_w     = (cnt_q == CW'(NBEAT - 1));
  assign hash_ready = (state_q == S_IDLE);
  assign pe_ready   = (state_q == S_COLLECT);
  assign out_valid  = (state_q == S_OUT);
  assign out_data   = out_q;

  // Even rows land in the high nibble of their byte, odd rows in the low nibble.
  always_comb begin
    beat_w = prod_q;
    sh_w   = '0;
    row_w  = 0;
    for (int j = 0; j < NPE; j++) begin
      sh_w  = pe_data[j*PE_W +: PE_W] >> SHIFT;
      row_w = int'(cnt_q) * NPE + j;
      beat_w[8*(row_w/2) + 4*(1 - row_w%2) +: 4] = sh_w[3:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    hash_d  = hash_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (hash_valid) begin
          hash_d  = hash_in;
          cnt_d   = '0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (pe_valid) begin
          prod_d = beat_w;
          if (last_w) begin
            out_d   = beat_w ^ hash_q;
            state_d = S_OUT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      hash_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      hash_q  <= hash_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_heavyhash_xor_pack.sv
// Scoreboard bench for heavyhash_xor_pack: directed nibble patterns,
// bubbles, output backpressure and mid-job reset/clr aborts.
module tb_heavyhash_xor_pack;

  logic         clk = 0;
  logic         rst_n, clr;
  logic         hash_valid, hash_ready;
  logic [255:0] hash_in;
  logic         pe_valid, pe_ready;
  logic [223:0] pe_data;
  logic         out_valid, out_ready;
  logic [255:0] out_data;

  int checks = 0;
  int errors = 0;
  int nout   = 0;

  logic [13:0]  rows [64];
  logic [255:0] sbq [$];
  logic [255:0] sb_exp;
  logic [255:0] r1, h0;

  heavyhash_xor_pack dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .hash_valid(hash_valid), .hash_in(hash_in), .hash_ready(hash_ready),
    .pe_valid(pe_valid), .pe_data(pe_data), .pe_ready(pe_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] model(input logic [255:0] h);
    logic [255:0] e;
    e = '0;
    for (int k = 0; k < 32; k++)
      e[8*k +: 8] = {rows[2*k][13:10], rows[2*k+1][13:10]};
    return e ^ h;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic rnd_rows();
    for (int r = 0; r < 64; r++) rows[r] = 14'($urandom_range(0, 16383));
  endtask

  task automatic fill_rows(input logic [13:0] v);
    for (int r = 0; r < 64; r++) rows[r] = v;
  endtask

  task automatic send_hash(input logic [255:0] h);
    int n = 0;
    hash_in = h;
    hash_valid = 1;
    while (!hash_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n == 50) chk("hash_timeout", 0, 1);
    @(posedge clk); #1;
    hash_valid = 0;
  endtask

  task automatic send_beat(input int b, input int maxbub);
    int n = 0;
    int nb = $urandom_range(0, maxbub);
    repeat (nb) begin
      @(posedge clk); #1;
    end
    pe_valid = 1;
    for (int j = 0; j < 16; j++) pe_data[j*14 +: 14] = rows[b*16 + j];
    while (!pe_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n == 50) chk("beat_timeout", 0, 1);
    @(posedge clk); #1;
    pe_valid = 0;
    pe_data  = 224'($urandom);
  endtask

  task automatic run_job(input logic [255:0] h, input int maxbub,
                         input int rdly);
    logic [255:0] held;
    sbq.push_back(model(h));
    send_hash(h);
    for (int b = 0; b < 4; b++) send_beat(b, maxbub);
    chk("latency", out_valid, 1);
    chk("out_hready", hash_ready, 0);
    chk("out_pready", pe_ready, 0);
    held = out_data;
    repeat (rdly) begin
      @(posedge clk); #1;
      chk("hold_data", out_data, held);
      chk("hold_valid", out_valid, 1);
      chk("hold_hready", hash_ready, 0);
      chk("hold_pready", pe_ready, 0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("valid_drop", out_valid, 0);
    chk("idle_hready", hash_ready, 1);
  endtask

  task automatic abort_job(input bit use_clr);
    rnd_rows();
    send_hash(rnd256());
    send_beat(0, 0);
    send_beat(1, 0);
    if (use_clr) clr = 1;
    else rst_n = 0;
    @(posedge clk); #1;
    clr = 0;
    rst_n = 1;
    chk("abort_valid", out_valid, 0);
    chk("abort_hready", hash_ready, 1);
    chk("abort_pready", pe_ready, 0);
    chk("abort_data", out_data, 0);
    rnd_rows();
    run_job(rnd256(), 1, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        sb_exp = sbq.pop_front();
        chk("scoreboard", out_data, sb_exp);
        nout++;
      end
    end
  end

  initial begin
    rst_n = 0; clr = 0;
    hash_valid = 0; hash_in = '0;
    pe_valid = 0; pe_data = '0;
    out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_hready", hash_ready, 1);
    chk("rst_pready", pe_ready, 0);

    fill_rows(14'h3FFF);
    run_job('0, 0, 0);
    chk("all_ff", out_data, {256{1'b1}});

    fill_rows(14'h2400);
    run_job({256{1'b1}}, 0, 0);
    chk("all_66", out_data, {32{8'h66}});

    fill_rows(14'h0);
    rows[0] = 14'h0400;
    rows[1] = 14'h0800;
    run_job('0, 0, 0);
    chk("row01", out_data, 256'h12);

    fill_rows(14'h0);
    rows[63] = 14'h3C00;
    run_job('0, 0, 0);
    chk("row63", out_data, {8'h0F, 248'h0});

    rnd_rows();
    h0 = rnd256();
    run_job(h0, 0, 0);
    r1 = out_data;
    run_job(h0, 3, 5);
    chk("bubble_eq", out_data, r1);

    abort_job(0);
    abort_job(1);

    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(sbq.size()), 0);
    chk("out_count", nout, 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
